// File: rtl/ram_pkg.sv
// Shared definitions for the RAM block-transfer engine: default widths,
// operation mode encodings and FSM state encoding.
package ram_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned AW_DEF = 6;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_addr_gen.sv
// Word index counter for ram_mover: produces wrapped source/destination
// addresses for the next access and flags the final word of a transfer.
module ram_addr_gen
    import ram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [AW:0]   i_len,
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_dst,
    output logic [AW-1:0] o_src_a_c,
    output logic [AW-1:0] o_dst_a_c,
    output logic          o_last_c
);

    logic [AW:0] r_i;
    logic [AW:0] w_i_inc;
    logic [AW:0] w_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
        end else if (i_clr) begin
            r_i <= '0;
        end else if (i_inc) begin
            r_i <= w_i_inc;
        end
    end

    assign w_i_inc = r_i + (AW + 1)'(1);

    // Index the following cycle will use, so the top can register its address.
    assign w_idx     = i_inc ? w_i_inc : r_i;
    assign o_src_a_c = i_src + w_idx[AW-1:0];
    assign o_dst_a_c = i_dst + w_idx[AW-1:0];
    assign o_last_c  = (w_i_inc == i_len);

endmodule

// File: rtl/ram_mover.sv
// Block-transfer engine for a single-port RAM: fills a word range with a
// constant or copies a range word by word in ascending order.
module ram_mover
    import ram_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_dst,
    input  logic [AW:0]   i_len,
    input  logic [DW-1:0] i_fill_val,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [AW-1:0] o_mem_a,
    output logic [DW-1:0] o_mem_d,
    output logic          o_mem_we,
    input  logic [DW-1:0] i_mem_q
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_e        r_state;
    logic          r_mode;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_len;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [AW-1:0] r_mem_a;
    logic [DW-1:0] r_mem_d;
    logic          r_mem_we;

    logic          w_clr;
    logic          w_inc;
    logic [AW-1:0] w_src_a;
    logic [AW-1:0] w_dst_a;
    logic          w_last;

    assign w_clr = (r_state == ST_IDLE) && i_start;
    assign w_inc = (r_state == ST_WR);

    ram_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .i_len     (r_len),
        .i_src     (r_src),
        .i_dst     (r_dst),
        .o_src_a_c (w_src_a),
        .o_dst_a_c (w_dst_a),
        .o_last_c  (w_last)
    );

    // r_mem_d doubles as the fill constant and the copy data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_FILL;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_a  <= '0;
            r_mem_d  <= '0;
            r_mem_we <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done   <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (i_start) begin
                        r_mode <= i_mode;
                        r_src  <= i_src;
                        r_dst  <= i_dst;
                        r_len  <= i_len;
                        r_err  <= 1'b0;
                        if (i_len == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else if (i_len > DEPTH) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (i_mode == MODE_FILL) begin
                            r_state  <= ST_WR;
                            r_busy   <= 1'b1;
                            r_mem_we <= 1'b1;
                            r_mem_a  <= i_dst;
                            r_mem_d  <= i_fill_val;
                        end else begin
                            r_state <= ST_RD;
                            r_busy  <= 1'b1;
                            r_mem_a <= i_src;
                        end
                    end
                end
                ST_RD: begin
                    r_state  <= ST_WR;
                    r_mem_we <= 1'b1;
                    r_mem_a  <= w_dst_a;
                    r_mem_d  <= i_mem_q;
                end
                ST_WR: begin
                    if (w_last) begin
                        r_state  <= ST_FIN;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_mem_we <= 1'b0;
                    end else if (r_mode == MODE_FILL) begin
                        r_mem_a <= w_dst_a;
                    end else begin
                        r_state  <= ST_RD;
                        r_mem_we <= 1'b0;
                        r_mem_a  <= w_src_a;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_mem_a  = r_mem_a;
    assign o_mem_d  = r_mem_d;
    assign o_mem_we = r_mem_we;

endmodule

// File: tb/tb_ram_mover.sv
// Testbench for ram_mover: a behavioural RAM plus a per-cycle model of the
// expected bus activity, with literal pins on key results.
module tb_ram_mover;

    localparam int DEPTH = 64;
    localparam int MAXC  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [5:0] src = '0;
    logic [5:0] dst = '0;
    logic [6:0] len = '0;
    logic [7:0] fv = '0;
    logic       busy, done, err, we;
    logic [5:0] ma;
    logic [7:0] md, mq;

    logic [7:0] ram [DEPTH];
    logic       ram_init = 1'b0;
    logic [7:0] mdl [DEPTH];

    bit e_busy [MAXC];
    bit e_done [MAXC];
    bit e_err  [MAXC];
    bit e_we   [MAXC];
    bit e_achk [MAXC];
    int e_a    [MAXC];
    int e_d    [MAXC];
    int exp_n = 0;

    int n_chk = 0;
    int n_err = 0;
    int req_id = 0;
    int seen_id = 0;
    int done_id = 0;
    int cyc = 0;
    int done_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= 8'(k * 7 + 3);
        end else if (we) begin
            ram[ma] <= md;
        end
    end
    assign mq = ram[ma];

    ram_mover dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_src      (src),
        .i_dst      (dst),
        .i_len      (len),
        .i_fill_val (fv),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_mem_a    (ma),
        .o_mem_d    (md),
        .o_mem_we   (we),
        .i_mem_q    (mq)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (op %0d cycle %0d): got %0d want %0d", nm, req_id, cyc, act, exp);
        end
    endtask

    // Expected per-cycle activity and final memory, from the transfer rules.
    task automatic build(input bit m, input int s, input int d, input int l,
                         input int fval, input int wr_lim, input int trunc);
        int n, t, wa, ra, wc;
        bit eo;
        logic [7:0] v;
        eo = (l > DEPTH);
        n  = eo ? 0 : l;
        t  = (n == 0) ? 1 : (m ? 2 * n + 1 : n + 1);
        for (int c = 1; c <= t + 2; c++) begin
            e_busy[c] = (c < t);
            e_done[c] = (c == t);
            e_err[c]  = eo && (c >= t);
            e_we[c]   = 1'b0;
            e_achk[c] = 1'b0;
            e_a[c]    = 0;
            e_d[c]    = 0;
        end
        for (int k = 0; k < n; k++) begin
            wa = (d + k) % DEPTH;
            ra = (s + k) % DEPTH;
            v  = m ? mdl[ra] : 8'(fval);
            if (m) begin
                wc = 2 * k + 2;
                e_achk[2 * k + 1] = 1'b1;
                e_a[2 * k + 1]    = ra;
            end else begin
                wc = k + 1;
            end
            e_we[wc]   = 1'b1;
            e_achk[wc] = 1'b1;
            e_a[wc]    = wa;
            e_d[wc]    = int'(v);
            if (k < wr_lim) mdl[wa] = v;
        end
        exp_n = (trunc > 0) ? trunc : t + 2;
    endtask

    task automatic launch(input bit m, input int s, input int d, input int l, input int fval);
        @(negedge clk);
        mode  = m;
        src   = 6'(s);
        dst   = 6'(d);
        len   = 7'(l);
        fv    = 8'(fval);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        req_id++;
    endtask

    task automatic wait_op();
        for (int k = 0; k < 400 && done_id != req_id; k++) begin
            @(negedge clk);
            #1;
        end
        if (done_id != req_id) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout op %0d: compare did not complete", req_id);
        end
    endtask

    task automatic check_mem();
        for (int k = 0; k < DEPTH; k++) begin
            n_chk++;
            if (ram[k] !== mdl[k]) begin
                n_err++;
                $display("FAIL ram[%0d] after op %0d: got %0d want %0d", k, req_id, ram[k], mdl[k]);
            end
        end
    endtask

    task automatic run_op(input bit m, input int s, input int d, input int l, input int fval);
        build(m, s, d, l, fval, DEPTH + 1, 0);
        launch(m, s, d, l, fval);
        wait_op();
        check_mem();
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (seen_id != req_id) begin
            seen_id  = req_id;
            cyc      = 1;
            done_cyc = 0;
        end
        if (cyc >= 1 && done_id != seen_id) begin
            chk("busy", int'(busy), int'(e_busy[cyc]));
            chk("done", int'(done), int'(e_done[cyc]));
            chk("err", int'(err), int'(e_err[cyc]));
            chk("mem_we", int'(we), int'(e_we[cyc]));
            if (e_achk[cyc]) chk("mem_a", int'(ma), e_a[cyc]);
            if (e_we[cyc]) chk("mem_d", int'(md), e_d[cyc]);
            if (done) done_cyc = cyc;
            if (cyc >= exp_n) done_id = seen_id;
            else cyc++;
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) mdl[k] = 8'(k * 7 + 3);
        @(negedge clk);
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_a", int'(ma), 0);
        chk("rst_d", int'(md), 0);
        rst = 1'b0;

        run_op(1'b0, 0, 2, 3, 100);
        chk("fill_done_cyc", done_cyc, 4);
        chk("fill_ram2", int'(ram[2]), 100);
        chk("fill_ram4", int'(ram[4]), 100);
        run_op(1'b0, 0, 3, 1, 48);
        run_op(1'b0, 0, 4, 1, 30);

        run_op(1'b1, 2, 12, 3, 0);
        chk("copy_done_cyc", done_cyc, 7);
        chk("copy_ram12", int'(ram[12]), 100);
        chk("copy_ram13", int'(ram[13]), 48);
        chk("copy_ram14", int'(ram[14]), 30);

        run_op(1'b0, 0, 62, 4, 8'hA5);
        chk("wrap_ram61", int'(ram[61]), 174);
        chk("wrap_ram2", int'(ram[2]), 100);
        chk("wrap_ram0", int'(ram[0]), 8'hA5);
        chk("wrap_ram63", int'(ram[63]), 8'hA5);

        run_op(1'b0, 0, 5, 0, 8'h77);
        chk("len0_done_cyc", done_cyc, 1);

        run_op(1'b1, 0, 5, 65, 0);
        chk("len65_done_cyc", done_cyc, 1);
        chk("len65_err_held", int'(err), 1);

        run_op(1'b1, 20, 21, 4, 0);
        chk("overlap_ram24", int'(ram[24]), 143);
        chk("overlap_err_clr", int'(err), 0);

        build(1'b0, 0, 40, 5, 8'h55, DEPTH + 1, 0);
        launch(1'b0, 0, 40, 5, 8'h55);
        @(negedge clk);
        dst   = 6'd50;
        len   = 7'd3;
        fv    = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_op();
        check_mem();
        chk("busy_start_done_cyc", done_cyc, 6);
        chk("busy_start_ram50", int'(ram[50]), 97);
        chk("busy_start_ram44", int'(ram[44]), 8'h55);

        build(1'b1, 0, 32, 10, 0, 2, 5);
        launch(1'b1, 0, 32, 10, 0);
        wait_op();
        @(negedge clk);
        chk("rst_mid_pre_we", int'(we), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", int'(we), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_done", int'(done), 0);
        end
        check_mem();
        chk("rst_mid_ram32", int'(ram[32]), 8'hA5);
        chk("rst_mid_ram33", int'(ram[33]), 8'hA5);
        chk("rst_mid_ram34", int'(ram[34]), 241);

        run_op(1'b0, 0, 10, 64, 8'h3C);
        chk("len64_done_cyc", done_cyc, 65);
        chk("len64_ram9", int'(ram[9]), 8'h3C);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
